// File: rtl/reverb_template_s2m_fifo0.sv
// Stream-to-MM return FIFO: Avalon-ST sink fills a register array, Avalon-MM read slave drains it and reports LEVEL/STATUS.
// Latency: a pushed word is poppable the next cycle; readdata is registered and valid one cycle after the read is accepted.
// Backpressure: sink_ready drops when full; a DATA read on an empty FIFO holds waitrequest until a word arrives.
module reverb_template_s2m_fifo0 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] avalonst_sink_data,
    input  logic              avalonst_sink_valid,
    output logic              avalonst_sink_ready,
    input  logic [1:0]        avalonmm_read_slave_address,
    input  logic              avalonmm_read_slave_read,
    output logic [DATA_W-1:0] avalonmm_read_slave_readdata,
    output logic              avalonmm_read_slave_waitrequest
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              push;
    logic              accept;
    logic              pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Both handshakes are forced inactive while reset is asserted.
    assign avalonst_sink_ready = reset_n & ~full;
    assign avalonmm_read_slave_waitrequest = ~reset_n |
        (avalonmm_read_slave_read & (avalonmm_read_slave_address == 2'd0) & empty);

    assign push   = avalonst_sink_valid & avalonst_sink_ready;
    assign accept = avalonmm_read_slave_read & ~avalonmm_read_slave_waitrequest;
    assign pop    = accept & (avalonmm_read_slave_address == 2'd0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= avalonst_sink_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // LEVEL/STATUS sample count before this edge's push/pop takes effect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avalonmm_read_slave_readdata <= '0;
        end else if (accept) begin
            case (avalonmm_read_slave_address)
                2'd0:    avalonmm_read_slave_readdata <= mem[rd_ptr[ADDR_W-1:0]];
                2'd1:    avalonmm_read_slave_readdata <= DATA_W'(count);
                2'd2:    avalonmm_read_slave_readdata <= DATA_W'({full, empty});
                default: avalonmm_read_slave_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_reverb_template_s2m_fifo0.sv
// Directed bench for the stream-to-MM return FIFO: reset, fill, drain, empty stall, concurrent wrap, mid-run reset.
module tb_reverb_template_s2m_fifo0;

    logic        clock;
    logic        reset_n;
    logic [31:0] sink_data;
    logic        sink_valid;
    logic        sink_ready;
    logic [1:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    int checks;
    int failures;
    logic [31:0] rd;
    logic [31:0] exp_q [$];
    logic [31:0] exp;

    reverb_template_s2m_fifo0 dut (
        .clock                           (clock),
        .reset_n                         (reset_n),
        .avalonst_sink_data              (sink_data),
        .avalonst_sink_valid             (sink_valid),
        .avalonst_sink_ready             (sink_ready),
        .avalonmm_read_slave_address     (address),
        .avalonmm_read_slave_read        (read),
        .avalonmm_read_slave_readdata    (readdata),
        .avalonmm_read_slave_waitrequest (waitrequest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called 1 time unit after a rising edge; returns with the same alignment.
    task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
        int n;
        n = 0;
        read = 1'b1;
        address = a;
        #3;
        while (waitrequest === 1'b1 && n < 50) begin
            @(posedge clock);
            #4;
            n++;
        end
        chk("mm_read_waitrequest", {31'd0, waitrequest}, 32'd0);
        @(posedge clock);
        #1;
        read = 1'b0;
        d = readdata;
    endtask

    task automatic push_word(input logic [31:0] d);
        sink_valid = 1'b1;
        sink_data = d;
        #3;
        chk("push_ready", {31'd0, sink_ready}, 32'd1);
        @(posedge clock);
        #1;
        sink_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        sink_data = '0;
        sink_valid = 1'b0;
        address = 2'd0;
        read = 1'b0;

        // Reset state
        #2;
        chk("rst_ready", {31'd0, sink_ready}, 32'd0);
        chk("rst_waitreq", {31'd0, waitrequest}, 32'd1);
        chk("rst_readdata", readdata, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_ready", {31'd0, sink_ready}, 32'd1);
        mm_read(2'd1, rd);
        chk("post_rst_level", rd, 32'd0);
        mm_read(2'd2, rd);
        chk("post_rst_status", rd, 32'h1);
        mm_read(2'd3, rd);
        chk("reserved_read", rd, 32'd0);

        // Fill back-to-back
        for (int i = 0; i < 32; i++) begin
            sink_valid = 1'b1;
            sink_data = 32'h100 + i;
            #3;
            chk("fill_ready", {31'd0, sink_ready}, 32'd1);
            @(posedge clock);
            #1;
        end
        sink_valid = 1'b0;
        chk("full_ready", {31'd0, sink_ready}, 32'd0);
        // Offered word while full must be refused.
        sink_valid = 1'b1;
        sink_data = 32'hDEAD;
        @(posedge clock);
        #1;
        sink_valid = 1'b0;
        mm_read(2'd1, rd);
        chk("full_level", rd, 32'd32);
        mm_read(2'd2, rd);
        chk("full_status", rd, 32'h2);

        // Drain
        for (int i = 0; i < 32; i++) begin
            mm_read(2'd0, rd);
            chk("drain_data", rd, 32'h100 + i);
        end
        mm_read(2'd2, rd);
        chk("drained_status", rd, 32'h1);

        // Empty stall released by a push
        read = 1'b1;
        address = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("stall_waitreq", {31'd0, waitrequest}, 32'd1);
            @(posedge clock);
            #1;
        end
        sink_valid = 1'b1;
        sink_data = 32'hABCD;
        #3;
        chk("stall_push_cycle_waitreq", {31'd0, waitrequest}, 32'd1);
        @(posedge clock);
        #1;
        sink_valid = 1'b0;
        #3;
        chk("stall_release_waitreq", {31'd0, waitrequest}, 32'd0);
        @(posedge clock);
        #1;
        read = 1'b0;
        chk("stall_readdata", readdata, 32'hABCD);

        // Concurrent push/pop around a standing level of 5
        for (int i = 0; i < 5; i++) begin
            push_word(32'h200 + i);
            exp_q.push_back(32'h200 + i);
        end
        for (int i = 0; i < 100; i++) begin
            sink_valid = 1'b1;
            sink_data = 32'h300 + i;
            read = 1'b1;
            address = 2'd0;
            #3;
            chk("conc_ready", {31'd0, sink_ready}, 32'd1);
            chk("conc_waitreq", {31'd0, waitrequest}, 32'd0);
            @(posedge clock);
            exp = exp_q.pop_front();
            exp_q.push_back(32'h300 + i);
            #1;
            chk("conc_data", readdata, exp);
        end
        sink_valid = 1'b0;
        read = 1'b0;
        mm_read(2'd1, rd);
        chk("conc_level", rd, 32'd5);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            mm_read(2'd0, rd);
            chk("conc_tail_data", rd, exp);
        end

        // Reset mid-operation at LEVEL=7
        for (int i = 0; i < 7; i++) begin
            push_word(32'h400 + i);
        end
        mm_read(2'd1, rd);
        chk("pre_rst_level", rd, 32'd7);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, sink_ready}, 32'd0);
        chk("midrst_waitreq", {31'd0, waitrequest}, 32'd1);
        chk("midrst_readdata", readdata, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("after_rst_ready", {31'd0, sink_ready}, 32'd1);
        chk("after_rst_readdata", readdata, 32'd0);
        mm_read(2'd1, rd);
        chk("after_rst_level", rd, 32'd0);
        mm_read(2'd2, rd);
        chk("after_rst_status", rd, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
